// File: rtl/block_hit_judge_if.sv
// Signal bundle between the block generator / player keys and the hit-judge back end.
// The master drives the field, strobe, start and keys; the slave returns game state and scores.
interface block_hit_judge_if #(
    parameter int SCORE_W = 16
);
    logic [63:0]        Disp_num;
    logic               EN;
    logic               start;
    logic [3:0]         key;
    logic [1:0]         state;
    logic [SCORE_W-1:0] score;
    logic [7:0]         combo;
    logic [7:0]         miss_cnt;
    logic               hit_pulse;
    logic               miss_pulse;

    modport master (
        output Disp_num, EN, start, key,
        input  state, score, combo, miss_cnt, hit_pulse, miss_pulse
    );

    modport slave (
        input  Disp_num, EN, start, key,
        output state, score, combo, miss_cnt, hit_pulse, miss_pulse
    );
endinterface

// File: rtl/block_hit_judge.sv
// Judges synchronized key presses against the bottom row of the falling-block field,
// keeps score/combo/miss counts and runs the IDLE/PLAY/OVER game state.
module block_hit_judge #(
    parameter int MAX_MISS = 8,
    parameter int SCORE_W  = 16
) (
    input logic          clk,
    input logic          rst,
    block_hit_judge_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_OVER = 2'b10
    } state_e;

    localparam logic [7:0] MAX_MISS_V = 8'(MAX_MISS);

    // EN is a plain one-cycle strobe (no ready): the field in Disp_num is only
    // consumed in the cycle EN is high, and the generator never waits on us.
    state_e             state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [7:0]         combo_q, combo_d;
    logic [7:0]         miss_cnt_q, miss_cnt_d;
    logic               hit_pulse_q, hit_pulse_d;
    logic               miss_pulse_q, miss_pulse_d;
    logic [3:0]         cur_row_q, cur_row_d;
    logic               judged_q, judged_d;
    logic [3:0]         ksync1_q, ksync1_d;
    logic [3:0]         ksync2_q, ksync2_d;
    logic [3:0]         khist_q, khist_d;
    logic               start_smp_q, start_smp_d;
    logic               start_hist_q, start_hist_d;

    logic [3:0]         kedge;
    logic               start_edge;
    logic [3:0]         row_eff;
    logic               judged_eff;
    logic               expire;
    logic               hit;
    logic               wrong;
    logic               any_miss;
    logic [8:0]         miss_sum;
    logic [7:0]         miss_sat;
    logic [7:0]         combo_base;
    logic               unused_bits;

    assign unused_bits = ^bus.Disp_num[63:4];

    function automatic logic is_onehot(input logic [3:0] r);
        return (r != 4'd0) && ((r & (r - 4'd1)) == 4'd0);
    endfunction

    always_comb begin
        ksync1_d     = bus.key;
        ksync2_d     = ksync1_q;
        khist_d      = ksync2_q;
        start_smp_d  = bus.start;
        start_hist_d = start_smp_q;

        kedge      = ksync2_q & ~khist_q;
        start_edge = start_smp_q & ~start_hist_q;

        // A key edge is judged against the row that is current after a same-cycle load.
        row_eff    = bus.EN ? bus.Disp_num[3:0] : cur_row_q;
        judged_eff = bus.EN ? 1'b0 : judged_q;
        expire     = bus.EN && is_onehot(cur_row_q) && !judged_q;
        hit        = (kedge != 4'd0) && is_onehot(row_eff) && !judged_eff && (kedge == row_eff);
        wrong      = (kedge != 4'd0) && !hit;
        any_miss   = expire || wrong;

        miss_sum   = {1'b0, miss_cnt_q} + {8'd0, expire} + {8'd0, wrong};
        miss_sat   = (miss_sum >= {1'b0, MAX_MISS_V}) ? MAX_MISS_V : miss_sum[7:0];
        combo_base = any_miss ? 8'd0 : combo_q;

        state_d      = state_q;
        score_d      = score_q;
        combo_d      = combo_q;
        miss_cnt_d   = miss_cnt_q;
        hit_pulse_d  = 1'b0;
        miss_pulse_d = 1'b0;
        cur_row_d    = cur_row_q;
        judged_d     = judged_q;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_edge) begin
                    state_d    = ST_PLAY;
                    score_d    = '0;
                    combo_d    = 8'd0;
                    miss_cnt_d = 8'd0;
                    cur_row_d  = 4'd0;
                    judged_d   = 1'b0;
                end
            end
            ST_PLAY: begin
                if (start_edge) begin
                    score_d    = '0;
                    combo_d    = 8'd0;
                    miss_cnt_d = 8'd0;
                    cur_row_d  = 4'd0;
                    judged_d   = 1'b0;
                end else begin
                    cur_row_d    = row_eff;
                    judged_d     = judged_eff || hit;
                    hit_pulse_d  = hit;
                    miss_pulse_d = any_miss;
                    if (hit) begin
                        score_d = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
                        combo_d = (combo_base == 8'hFF) ? combo_base : combo_base + 8'd1;
                    end else begin
                        combo_d = combo_base;
                    end
                    if (any_miss) begin
                        miss_cnt_d = miss_sat;
                        if (miss_sat == MAX_MISS_V) begin
                            state_d = ST_OVER;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            score_q      <= '0;
            combo_q      <= 8'd0;
            miss_cnt_q   <= 8'd0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            cur_row_q    <= 4'd0;
            judged_q     <= 1'b0;
            ksync1_q     <= 4'd0;
            ksync2_q     <= 4'd0;
            khist_q      <= 4'd0;
            start_smp_q  <= 1'b0;
            start_hist_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            combo_q      <= combo_d;
            miss_cnt_q   <= miss_cnt_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
            cur_row_q    <= cur_row_d;
            judged_q     <= judged_d;
            ksync1_q     <= ksync1_d;
            ksync2_q     <= ksync2_d;
            khist_q      <= khist_d;
            start_smp_q  <= start_smp_d;
            start_hist_q <= start_hist_d;
        end
    end

    assign bus.state      = state_q;
    assign bus.score      = score_q;
    assign bus.combo      = combo_q;
    assign bus.miss_cnt   = miss_cnt_q;
    assign bus.hit_pulse  = hit_pulse_q;
    assign bus.miss_pulse = miss_pulse_q;

endmodule
